// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing derivations and receiver FSM encoding, used by both driver and receiver
// so that both ends of the link agree on pulse widths.
package ws2812_pkg;

  function automatic int unsigned bit_thresh_cycles(input int unsigned clk_mhz);
    return clk_mhz * 600 / 1000;
  endfunction

  function automatic int unsigned high_max_cycles(input int unsigned clk_mhz);
    return clk_mhz * 1600 / 1000;
  endfunction

  function automatic int unsigned latch_cycles(input int unsigned clk_mhz);
    return clk_mhz * 50;
  endfunction

  localparam int unsigned CLK_MHZ_DEFAULT = 12;
  localparam int unsigned T_BIT_THRESH    = bit_thresh_cycles(CLK_MHZ_DEFAULT);
  localparam int unsigned T_HIGH_MAX      = high_max_cycles(CLK_MHZ_DEFAULT);
  localparam int unsigned T_LATCH         = latch_cycles(CLK_MHZ_DEFAULT);

  typedef enum logic [1:0] {
    StSync,
    StIdle,
    StHigh,
    StLow
  } rx_state_e;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 data pin plus edge detection on the
// synchronized level.
module ws2812_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic ds_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, ds_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      ds_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      ds_q   <= meta_q;
      prev_q <= ds_q;
    end
  end

  assign ds_o   = ds_q;
  assign rise_o = ds_q & ~prev_q;
  assign fall_o = ~ds_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: classifies bits by high-pulse width, assembles GRB words into a shadow
// buffer and publishes a whole frame atomically when the latch gap is seen.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 16,
  parameter int unsigned CLK_MHZ  = 12
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  din,
  output logic [24*NUM_LEDS-1:0] packed_rgb_data,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [7:0]            led_count
);

  localparam int unsigned TBitThresh = bit_thresh_cycles(CLK_MHZ);
  localparam int unsigned THighMax   = high_max_cycles(CLK_MHZ);
  localparam int unsigned TLatch     = latch_cycles(CLK_MHZ);
  localparam int unsigned CntW       = $clog2(TLatch + 1);

  localparam logic [CntW-1:0] CntBit     = CntW'(TBitThresh);
  localparam logic [CntW-1:0] CntHighMax = CntW'(THighMax);
  localparam logic [CntW-1:0] CntLatch   = CntW'(TLatch);
  localparam logic [7:0]      NumLedsW   = 8'(NUM_LEDS);

  logic ds, rise, fall;

  ws2812_rx_sync u_sync (
    .clk_i  (CLK),
    .rst_i  (reset),
    .din_i  (din),
    .ds_o   (ds),
    .rise_o (rise),
    .fall_o (fall)
  );

  rx_state_e state_q, state_d;

  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [4:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              word_idx_q, word_idx_d;
  logic [23:0]             word_q, word_d;
  logic [24*NUM_LEDS-1:0]  shadow_q, shadow_d;
  logic [24*NUM_LEDS-1:0]  packed_q, packed_d;
  logic [7:0]              count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;

  logic sync_done, bit_done, high_err, eof, eof_good, eof_bad;

  assign cnt_inc = cnt_q + CntW'(1);

  // Cycles since the last edge of ds, saturating at the latch gap.
  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall) begin
      cnt_d = '0;
    end else if (cnt_q != CntLatch) begin
      cnt_d = cnt_inc;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM outputs: per-cycle actions decoded from state and line events.
  always_comb begin
    sync_done = 1'b0;
    high_err  = 1'b0;
    bit_done  = 1'b0;
    eof       = 1'b0;
    unique case (state_q)
      StSync: sync_done = ~ds & ~fall & (cnt_q == CntLatch);
      StHigh: begin
        high_err = (cnt_inc >= CntHighMax);
        bit_done = fall & ~high_err;
      end
      StLow:  eof = (cnt_q == CntLatch);
      default: ;
    endcase
    eof_good = eof & (bit_idx_q == 5'd0) & (word_idx_q != 8'd0);
    eof_bad  = eof & (bit_idx_q != 5'd0);
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync: if (sync_done) state_d = StIdle;
      StIdle: if (rise) state_d = StHigh;
      StHigh: begin
        if (high_err) begin
          state_d = StSync;
        end else if (fall) begin
          state_d = StLow;
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
        end else if (eof) begin
          state_d = StIdle;
        end
      end
      default: state_d = StSync;
    endcase
  end

  // Word assembly, shadow buffer and frame publication.
  always_comb begin
    bit_idx_d  = bit_idx_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    shadow_d   = shadow_q;
    packed_d   = packed_q;
    count_d    = count_q;
    valid_d    = eof_good;
    error_d    = eof_bad | high_err;

    if (bit_done) begin
      word_d = {word_q[22:0], (cnt_inc >= CntBit)};
      if (bit_idx_q == 5'd23) begin
        bit_idx_d = 5'd0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
          if (word_idx_q == 8'(i)) begin
            shadow_d[24*i +: 24] = word_d;
          end
        end
        if (word_idx_q != 8'hFF) begin
          word_idx_d = word_idx_q + 8'd1;
        end
      end else begin
        bit_idx_d = bit_idx_q + 5'd1;
      end
    end

    if (eof_good) begin
      packed_d = shadow_q;
      count_d  = (word_idx_q > NumLedsW) ? NumLedsW : word_idx_q;
    end

    // A discarded or finished frame always restarts word assembly from scratch.
    if (eof || high_err) begin
      bit_idx_d  = 5'd0;
      word_idx_d = 8'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q      <= '0;
      bit_idx_q  <= 5'd0;
      word_idx_q <= 8'd0;
      word_q     <= 24'd0;
      shadow_q   <= '0;
      packed_q   <= '0;
      count_q    <= 8'd0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
      shadow_q   <= shadow_d;
      packed_q   <= packed_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign packed_rgb_data = packed_q;
  assign frame_valid     = valid_q;
  assign frame_error     = error_q;
  assign led_count       = count_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: directed and randomized pulse streams checked against a frame-level
// model that decodes pulse widths straight from the timing rules.
module tb_ws2812_rx;

  localparam int unsigned NL      = 2;
  localparam int unsigned MHZ     = 12;
  localparam int          TB_THR  = MHZ * 600 / 1000;
  localparam int          TB_HMAX = MHZ * 1600 / 1000;
  localparam int          GAP     = 650;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [47:0] packed_o;
  logic        fv, fe;
  logic [7:0]  cnt_o;

  always #5 clk = ~clk;

  ws2812_rx #(
    .NUM_LEDS (NL),
    .CLK_MHZ  (MHZ)
  ) dut (
    .CLK             (clk),
    .reset           (rst),
    .din             (din),
    .packed_rgb_data (packed_o),
    .frame_valid     (fv),
    .frame_error     (fe),
    .led_count       (cnt_o)
  );

  int vcnt = 0;
  int ecnt = 0;
  int both_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(negedge clk) begin
    if (fv === 1'b1) vcnt++;
    if (fe === 1'b1) ecnt++;
    if (fv === 1'b1 && fe === 1'b1) both_cnt++;
  end

  int hw[$];
  int lw[$];
  logic [23:0] m_shadow[NL];
  logic [47:0] m_packed;
  logic [7:0]  m_count;

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [23:0] w, input int h0, input int h1, input int l0,
                           input int l1);
    for (int b = 23; b >= 0; b--) begin
      hw.push_back(w[b] ? h1 : h0);
      lw.push_back(w[b] ? l1 : l0);
    end
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) hw.push_back(int'($urandom_range(7, 18)));
      else hw.push_back(int'($urandom_range(2, 6)));
      lw.push_back(int'($urandom_range(3, 12)));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_shadow[i] = 24'd0;
    m_packed = 48'd0;
    m_count  = 8'd0;
  endtask

  // kind: 0 no pulse, 1 frame_valid, 2 frame_error
  task automatic model(output int kind);
    logic [23:0] cur;
    int nb, nw;
    cur = 24'd0; nb = 0; nw = 0; kind = 0;
    foreach (hw[i]) begin
      if (hw[i] >= TB_HMAX) begin
        kind = 2;
        return;
      end
      cur = {cur[22:0], (hw[i] >= TB_THR)};
      nb++;
      if (nb == 24) begin
        if (nw < NL) m_shadow[nw] = cur;
        if (nw < 255) nw++;
        nb = 0;
      end
    end
    if (nb != 0) begin
      kind = 2;
    end else if (nw > 0) begin
      kind = 1;
      m_count = 8'((nw > NL) ? NL : nw);
      for (int i = 0; i < NL; i++) m_packed[24*i +: 24] = m_shadow[i];
    end
  endtask

  task automatic run_frame(output int kind, output int dv, output int de);
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    model(kind);
    foreach (hw[i]) begin
      drive(1'b1, hw[i]);
      drive(1'b0, lw[i]);
    end
    drive(1'b0, GAP);
    dv = vcnt - v0;
    de = ecnt - e0;
    hw.delete();
    lw.delete();
  endtask

  task automatic test_reset();
    din = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (packed_o !== 48'd0) $display("FAIL reset_packed: got %h want 0", packed_o); else n_pass++;
    n_checks++; if (cnt_o !== 8'd0) $display("FAIL reset_count: got %0d want 0", cnt_o); else n_pass++;
    n_checks++; if (fv !== 1'b0) $display("FAIL reset_valid: got %b want 0", fv); else n_pass++;
    n_checks++; if (fe !== 1'b0) $display("FAIL reset_error: got %b want 0", fe); else n_pass++;
    rst = 1'b0;
    model_reset();
    drive(1'b0, GAP);
  endtask

  task automatic test_basic();
    int k, dv, de;
    push_word(24'hFF0000, 5, 10, 10, 5);
    push_word(24'h00FF00, 5, 10, 10, 5);
    run_frame(k, dv, de);
    n_checks++; if (dv !== 1) $display("FAIL basic_valid: got %0d pulses want 1", dv); else n_pass++;
    n_checks++; if (de !== 0) $display("FAIL basic_error: got %0d pulses want 0", de); else n_pass++;
    n_checks++; if (packed_o !== 48'h00FF00_FF0000) $display("FAIL basic_packed: got %h want 00ff00ff0000", packed_o); else n_pass++;
    n_checks++; if (cnt_o !== 8'd2) $display("FAIL basic_count: got %0d want 2", cnt_o); else n_pass++;
  endtask

  task automatic test_threshold();
    int k, dv, de;
    push_word(24'hFFFFFF, 5, 6, 10, 10);
    push_word(24'hFFFFFF, 5, 7, 10, 10);
    run_frame(k, dv, de);
    n_checks++; if (dv !== 1) $display("FAIL thresh_valid: got %0d want 1", dv); else n_pass++;
    n_checks++; if (packed_o !== 48'hFFFFFF_000000) $display("FAIL thresh_packed: got %h want ffffff000000", packed_o); else n_pass++;
    n_checks++; if (packed_o !== m_packed) $display("FAIL thresh_model: got %h want %h", packed_o, m_packed); else n_pass++;
  endtask

  task automatic test_high_error();
    int k, dv, de;
    logic [47:0] p;
    push_word(24'($urandom), 5, 10, 10, 5);
    push_word(24'($urandom), 5, 10, 10, 5);
    run_frame(k, dv, de);
    n_checks++; if (dv !== 1) $display("FAIL herr_first_valid: got %0d want 1", dv); else n_pass++;
    p = packed_o;
    n_checks++; if (p !== m_packed) $display("FAIL herr_first_packed: got %h want %h", p, m_packed); else n_pass++;
    push_word(24'($urandom), 5, 10, 10, 5);
    push_word(24'($urandom), 5, 10, 10, 5);
    hw[$urandom_range(0, 47)] = TB_HMAX;
    run_frame(k, dv, de);
    n_checks++; if (de !== 1) $display("FAIL herr_error: got %0d pulses want 1", de); else n_pass++;
    n_checks++; if (dv !== 0) $display("FAIL herr_valid: got %0d pulses want 0", dv); else n_pass++;
    n_checks++; if (packed_o !== p) $display("FAIL herr_hold: got %h want %h", packed_o, p); else n_pass++;
    push_word(24'($urandom), 5, 10, 10, 5);
    push_word(24'($urandom), 5, 10, 10, 5);
    run_frame(k, dv, de);
    n_checks++; if (dv !== 1) $display("FAIL herr_recover_valid: got %0d want 1", dv); else n_pass++;
    n_checks++; if (packed_o !== m_packed) $display("FAIL herr_recover_packed: got %h want %h", packed_o, m_packed); else n_pass++;
  endtask

  task automatic test_overflow();
    int k, dv, de;
    push_word(24'hAA5500, 5, 10, 10, 5);
    push_word(24'h0011FF, 5, 10, 10, 5);
    push_word(24'h123456, 5, 10, 10, 5);
    run_frame(k, dv, de);
    n_checks++; if (dv !== 1) $display("FAIL ovf_valid: got %0d want 1", dv); else n_pass++;
    n_checks++; if (de !== 0) $display("FAIL ovf_error: got %0d want 0", de); else n_pass++;
    n_checks++; if (packed_o !== 48'h0011FF_AA5500) $display("FAIL ovf_packed: got %h want 0011ffaa5500", packed_o); else n_pass++;
    n_checks++; if (cnt_o !== 8'd2) $display("FAIL ovf_count: got %0d want 2", cnt_o); else n_pass++;
  endtask

  task automatic test_partial();
    int k, dv, de;
    logic [47:0] p;
    logic [7:0]  pc;
    p = packed_o; pc = cnt_o;
    push_word(24'($urandom), 5, 10, 10, 5);
    push_rand_bits(6);
    run_frame(k, dv, de);
    n_checks++; if (de !== 1) $display("FAIL partial_error: got %0d want 1", de); else n_pass++;
    n_checks++; if (dv !== 0) $display("FAIL partial_valid: got %0d want 0", dv); else n_pass++;
    n_checks++; if (packed_o !== p) $display("FAIL partial_packed: got %h want %h", packed_o, p); else n_pass++;
    n_checks++; if (cnt_o !== pc) $display("FAIL partial_count: got %0d want %0d", cnt_o, pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k, dv, de, v0, e0;
    push_word(24'($urandom), 5, 10, 10, 5);
    push_word(24'($urandom), 5, 10, 10, 5);
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, hw[i]);
      drive(1'b0, lw[i]);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_checks++; if (packed_o !== 48'd0) $display("FAIL rmid_packed: got %h want 0", packed_o); else n_pass++;
    n_checks++; if (cnt_o !== 8'd0) $display("FAIL rmid_count: got %0d want 0", cnt_o); else n_pass++;
    for (int i = 10; i < 48; i++) begin
      drive(1'b1, hw[i]);
      drive(1'b0, lw[i]);
    end
    drive(1'b0, GAP);
    hw.delete();
    lw.delete();
    n_checks++; if (vcnt - v0 !== 0) $display("FAIL rmid_no_valid: got %0d want 0", vcnt - v0); else n_pass++;
    n_checks++; if (ecnt - e0 !== 0) $display("FAIL rmid_no_error: got %0d want 0", ecnt - e0); else n_pass++;
    push_word(24'($urandom), 5, 10, 10, 5);
    run_frame(k, dv, de);
    n_checks++; if (dv !== 1) $display("FAIL rmid_recover_valid: got %0d want 1", dv); else n_pass++;
    n_checks++; if (packed_o !== m_packed) $display("FAIL rmid_recover_packed: got %h want %h", packed_o, m_packed); else n_pass++;
    n_checks++; if (cnt_o !== 8'd1) $display("FAIL rmid_recover_count: got %0d want 1", cnt_o); else n_pass++;
  endtask

  task automatic test_random();
    int k, dv, de, nwords, mode;
    for (int it = 0; it < 8; it++) begin
      nwords = int'($urandom_range(1, 3));
      push_rand_bits(24 * nwords);
      mode = int'($urandom_range(0, 5));
      if (mode == 0) push_rand_bits(int'($urandom_range(1, 23)));
      if (mode == 1) hw[$urandom_range(0, 24 * nwords - 1)] = int'($urandom_range(19, 22));
      run_frame(k, dv, de);
      n_checks++; if (dv !== ((k == 1) ? 1 : 0)) $display("FAIL rand%0d_valid: got %0d want %0d", it, dv, (k == 1) ? 1 : 0); else n_pass++;
      n_checks++; if (de !== ((k == 2) ? 1 : 0)) $display("FAIL rand%0d_error: got %0d want %0d", it, de, (k == 2) ? 1 : 0); else n_pass++;
      n_checks++; if (packed_o !== m_packed) $display("FAIL rand%0d_packed: got %h want %h", it, packed_o, m_packed); else n_pass++;
      n_checks++; if (cnt_o !== m_count) $display("FAIL rand%0d_count: got %0d want %0d", it, cnt_o, m_count); else n_pass++;
    end
  endtask

  task automatic test_exclusive();
    n_checks++; if (both_cnt !== 0) $display("FAIL exclusive: got %0d overlapping cycles want 0", both_cnt); else n_pass++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, limit 900000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    din = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_threshold();
    test_high_error();
    test_overflow();
    test_partial();
    test_reset_mid();
    test_random();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
